data_mem_ws: RTL and testbench

//  Parametrised data memory for the RISC-V core's load/store path: word-organised RAM with byte-lane

---
 rtl/data_mem_ws_pkg.sv | 19 +
 rtl/data_mem_ws_ram.sv | 26 ++
 rtl/data_mem_ws.sv | 99 +++++++++
 tb/tb_data_mem_ws.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ws_pkg.sv
// Shared types and helpers for the wait-state data memory.
// lane_mask_merge works on a fixed maximum width; callers zero-extend and truncate.
package data_mem_ws_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  localparam int WS_W  = 4;
  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;

  function automatic logic [MAX_W-1:0] lane_mask_merge(input logic [MAX_W-1:0] old_w,
                                                       input logic [MAX_W-1:0] new_w,
                                                       input logic [MAX_B-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int k = 0; k < MAX_B; k++)
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction
endpackage

// File: rtl/data_mem_ws_ram.sv
// Word-organised RAM with byte-lane writes and a registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module data_mem_ws_ram
  import data_mem_ws_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic                       i_re,
  input  logic [DATA_W/8-1:0]        i_be,
  input  logic [$clog2(DEPTH)-1:0]   i_idx,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W-1:0]          o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_idx] <= DATA_W'(lane_mask_merge(MAX_W'(r_mem[i_idx]), MAX_W'(i_wdata),
                                              MAX_B'(i_be)));
    if (i_re)
      o_rdata <= r_mem[i_idx];
  end
endmodule

// File: rtl/data_mem_ws.sv
// Load/store data memory with req/ready handshake and WAIT_STATES extra busy cycles.
// RAM commits writes and captures reads on the accept edge; the FSM only times the response.
module data_mem_ws
  import data_mem_ws_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4096,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_req_i,
  input  logic                write_enable_i,
  input  logic [DATA_W/8-1:0] byte_enable_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   write_data_i,
  output logic                ready_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   read_data_o,
  output logic                err_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  state_e              r_state;
  logic [WS_W-1:0]     r_cnt;
  logic                r_rd;
  logic                r_err;
  logic [DATA_W-1:0]   r_hold;

  logic                w_accept;
  logic                w_misal;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_q;
  logic                w_unused_addr;

  // Upper address bits alias onto the same word.
  assign w_idx         = addr_i[OFF_W +: IDX_W];
  assign w_unused_addr = ^addr_i;

  if (OFF_W > 0) begin : g_off
    assign w_misal = |addr_i[OFF_W-1:0];
  end else begin : g_nooff
    assign w_misal = 1'b0;
  end

  assign ready_o  = (r_state == IDLE) | ((WAIT_STATES == 0) & (r_state == RESP));
  assign w_accept = mem_req_i & ready_o;

  data_mem_ws_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_accept &  write_enable_i & ~w_misal),
    .i_re    (w_accept & ~write_enable_i & ~w_misal),
    .i_be    (byte_enable_i),
    .i_idx   (w_idx),
    .i_wdata (write_data_i),
    .o_rdata (w_q)
  );

  // Reads show the RAM word during RESP; r_hold keeps the last completed value afterwards.
  assign rvalid_o    = (r_state == RESP) & (r_rd | r_err);
  assign err_o       = (r_state == RESP) & r_err;
  assign read_data_o = rvalid_o ? (r_err ? '0 : w_q) : r_hold;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= '0;
    end else begin
      if (rvalid_o) r_hold <= read_data_o;
      if (w_accept) begin
        r_rd  <= ~write_enable_i;
        r_err <= w_misal;
      end
      case (r_state)
        IDLE:
          if (w_accept) begin
            if (WAIT_STATES > 0) begin
              r_state <= WAIT;
              r_cnt   <= WS_W'(WAIT_STATES - 1);
            end else begin
              r_state <= RESP;
            end
          end
        WAIT:
          if (r_cnt == '0) r_state <= RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        // Accept in RESP is only possible with zero wait states.
        RESP:    r_state <= w_accept ? RESP : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboarded random + directed bench driving three memories with 1, 0 and 3 wait states.
module tb_data_mem_ws;
  localparam int NI = 3;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        req   [NI];
  logic        we    [NI];
  logic [3:0]  be    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wd    [NI];
  logic        ready [NI];
  logic        rvalid[NI];
  logic        err   [NI];
  logic [31:0] rd    [NI];

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [31:0] model[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_mem_ws #(.DATA_W(32), .DEPTH(4096), .ADDR_W(32),
                  .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .mem_req_i      (req[g]),
      .write_enable_i (we[g]),
      .byte_enable_i  (be[g]),
      .addr_i         (addr[g]),
      .write_data_i   (wd[g]),
      .ready_o        (ready[g]),
      .rvalid_o       (rvalid[g]),
      .read_data_o    (rd[g]),
      .err_o          (err[g])
    );
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic int key_of(input int i, input logic [31:0] a);
    return i * 4096 + int'((a >> 2) & 32'h0000_0FFF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input int i, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    exp_t        e;
    logic [31:0] word;
    bit          mis;
    int          k;
    k = 0;
    while (!ready[i] && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ready[i]) begin
      chk("ready_timeout", 32'(ready[i]), 1);
      return;
    end
    mis = (a[1:0] != 2'b00);
    e.inst = i;
    e.due  = cyc + 1 + ws_of(i);
    e.err  = mis;
    e.data = 0;
    if (w && !mis) begin
      word = model.exists(key_of(i, a)) ? model[key_of(i, a)] : 32'h0;
      for (int j = 0; j < 4; j++)
        if (b[j]) word[8*j +: 8] = d[8*j +: 8];
      model[key_of(i, a)] = word;
    end else if (!w && !mis) begin
      e.data = model[key_of(i, a)];
    end
    if (!w || mis) exp_q.push_back(e);
    req[i] = 1; we[i] = w; addr[i] = a; wd[i] = d; be[i] = b;
    @(posedge clk); #1;
    req[i] = 0;
    if (ws_of(i) == 0) chk($sformatf("ready_after_accept[%0d]", i), 32'(ready[i]), 1);
    else               chk($sformatf("ready_after_accept[%0d]", i), 32'(ready[i]), 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("err_gated[%0d]", i), 32'(err[i] & ~rvalid[i]), 0);
        if (rvalid[i]) begin
          chk($sformatf("rvalid_expected[%0d]", i), 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_inst", i, e.inst);
            chk($sformatf("rdata[%0d]", i), rd[i], e.data);
            chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(e.err));
            chk($sformatf("latency_cycle[%0d]", i), cyc, e.due);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < NI; i++) begin
      req[i] = 0; we[i] = 0; be[i] = 0; addr[i] = 0; wd[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 16; w++) issue(i, 1, 32'(w * 4), $urandom, 4'hF);
    drain();

    // WS=1 full word, byte lanes, misaligned
    issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(0, 0, 32'h10, 0, 0);
    issue(0, 1, 32'h10, 32'h11223344, 4'b0101);
    issue(0, 0, 32'h10, 0, 0);
    issue(0, 0, 32'h13, 0, 0);
    issue(0, 1, 32'h12, 32'hFFFFFFFF, 4'hF);
    issue(0, 0, 32'h10, 0, 0);
    issue(0, 1, 32'h14, 32'h0BADF00D, 4'h0);
    issue(0, 0, 32'h14, 0, 0);
    drain();

    // WS=0 back-to-back and aliasing
    issue(1, 1, 32'h20, 32'hA5A55A5A, 4'hF);
    issue(1, 0, 32'h20, 0, 0);
    issue(1, 0, 32'h4020, 0, 0);
    issue(1, 0, 32'h21, 0, 0);
    issue(1, 1, 32'h4024, 32'h01020304, 4'b1010);
    issue(1, 0, 32'h24, 0, 0);
    drain();

    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 60; n++) begin
        a = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        issue(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end
      drain();
    end

    // Async reset mid-cycle
    issue(0, 0, 32'h10, 0, 0);
    drain();
    @(posedge clk); #2;
    rst = 1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ready[%0d]", i), 32'(ready[i]), 1);
      chk($sformatf("rst_rvalid[%0d]", i), 32'(rvalid[i]), 0);
      chk($sformatf("rst_rdata[%0d]", i), rd[i], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // Reset during WAIT of a read on WS=3
    issue(2, 1, 32'h30, 32'hCAFEF00D, 4'hF);
    drain();
    issue(2, 0, 32'h30, 0, 0);
    #2 rst = 1;
    exp_q.delete();
    #1 chk("rst_wait_rvalid", 32'(rvalid[2]), 0);
    @(posedge clk); #1 rst = 0;
    repeat (8) @(posedge clk);
    #1;
    issue(2, 0, 32'h30, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
